muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the HI/LO multiply/divide resource beside the single-cycle ALU in the EX stage.
- Accepts MULT/MULTU/DIV/DIVU issued from EX, runs a 32-iteration radix-2 shift-add (mult) or restoring-subtract (div) loop, and owns the HI/LO registers.
- Exports Busy so the hazard unit stalls MFHI/MFLO and further mult/div issue until the result lands.

Parameters:
- WIDTH, 32, operand width; the iteration counter is clog2(WIDTH) bits.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- Start  in  1  issue strobe, sampled only in IDLE
- Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  in  WIDTH  rs operand
- B  in  WIDTH  rt operand
- HiWrite  in  1  MTHI write enable
- LoWrite  in  1  MTLO write enable
- WData  in  WIDTH  MTHI/MTLO data
- Busy  out  1  operation in flight (stall request)
- Done  out  1  one-cycle pulse, result committed
- DivZero  out  1  one-cycle pulse with Done, DIV/DIVU divisor was 0
- Hi  out  WIDTH  HI register
- Lo  out  WIDTH  LO register

Behaviour:
- Reset values: Hi=0, Lo=0, Busy=0, Done=0, DivZero=0, state=IDLE, counter=0. Reset mid-operation aborts to IDLE with these values and discards the operation.
- States: IDLE, CALC, FIX.
- IDLE with Start=1 (cycle t):
  - latch |A|, |B| for signed ops (A, B unsigned for MULTU/DIVU);
  - latch neg_res = sa^sb and neg_rem = sa;
  - clear the accumulator and counter;
  - go to CALC.
- DIV/DIVU with B=0 at Start: no CALC. Hi/Lo unchanged; Done=1 and DivZero=1 in cycle t+1; state stays IDLE; Busy stays 0.
- CALC: one iteration per cycle, counter 0..WIDTH-1. After the iteration with counter=WIDTH-1, go to FIX.
  - Mult: 2*WIDTH-bit product, shift-add on the multiplier LSB.
  - Div: restoring, one quotient bit per cycle, MSB first.
- FIX (one cycle), result written to Hi/Lo at the end of the cycle, then go to IDLE:
  - Mult: if neg_res, negate the 64-bit product; Hi=product[63:32], Lo=product[31:0].
  - Div: Lo = quotient, negated if neg_res; Hi = remainder, negated if neg_rem.
- Timing: Busy=1 in cycles t+1..t+WIDTH+1. Hi/Lo new values and Done=1 in cycle t+WIDTH+2 (t+34 for WIDTH=32).
- Arithmetic edge cases:
  - |0x80000000| is handled as unsigned 0x80000000 (no overflow in the magnitude path).
  - DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0 (natural wrap).
- Start while Busy: ignored, no queuing; the hazard unit must not issue.
- HiWrite/LoWrite: honoured only when Busy=0, write lands at the clock edge.
  - Ignored while Busy.
  - In IDLE with Start also high, the write lands first and the operation result later overwrites it.
- Done and DivZero are registered; they are never high for more than one cycle.
- Op and A/B are sampled only in the Start cycle; later changes have no effect.

Decomposition:
- Shared package:
  - Op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - state encodings S_IDLE, S_CALC, S_FIX;
  - the WIDTH default.
- Sub-module md_step (combinational, one iteration):
  - inputs: partial accumulator, operand, mode;
  - outputs: next accumulator, quotient bit.
  - Instantiated once inside the sequencer.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7, Start at t -> Busy t+1..t+33; Done at t+34; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001 at t+34.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU 100/7 -> Lo=14, Hi=2.
- DIVU A=100, B=0 with Hi=0x11, Lo=0x22 preloaded via MTHI/MTLO -> Done=DivZero=1 at t+1; Hi/Lo stay 0x11/0x22; Busy never asserts.
- Start a MULT, pulse Start (DIVU 9/3) and HiWrite (0xAAAA) at t+5 -> both ignored; result equals the original MULT.
- Start a MULT, assert Reset at t+10 -> next cycle Busy=0, Hi=Lo=0, no Done pulse; a fresh op afterwards completes correctly.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_sequencer_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

endpackage

// File: rtl/muldiv_sequencer_md_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a
// {upper, lower} accumulator holding unsigned magnitudes.
module md_step
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_operand,
  input  logic               i_div,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_qbit
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shift_rem;
  logic [WIDTH:0] w_trial;

  // Divide leaves bit 0 of o_acc clear; the caller merges o_qbit there.
  always_comb begin
    o_acc       = '0;
    o_qbit      = 1'b0;
    w_sum       = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    w_shift_rem = i_acc[2*WIDTH-1:WIDTH-1];
    w_trial     = w_shift_rem - {1'b0, i_operand};
    if (i_div) begin
      o_qbit = ~w_trial[WIDTH];
      o_acc  = {(o_qbit ? w_trial[WIDTH-1:0] : w_shift_rem[WIDTH-1:0]),
                i_acc[WIDTH-2:0], 1'b0};
    end else begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner: runs MULT/MULTU/DIV/DIVU over WIDTH iterations plus a sign-fix
// cycle, and stalls the pipeline through o_busy while an operation is in flight.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_hi_write,
  input  logic             i_lo_write,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [1:0]       o_state
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div_zero;

  logic               w_op_div;
  logic               w_op_signed;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_step_acc;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_op_div    = i_op[1];
  assign w_op_signed = ~i_op[0];

  // Negating 0x80000000 wraps to itself, which is the correct unsigned magnitude.
  always_comb begin
    w_abs_a = (w_op_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    w_abs_b = (w_op_signed && i_b[WIDTH-1]) ? -i_b : i_b;
  end

  always_comb begin
    w_prod_fix = r_neg_res ? -r_acc : r_acc;
    w_quot_fix = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem_fix  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end

  md_step #(.WIDTH(WIDTH)) u_step (
    .i_acc     (r_acc),
    .i_operand (r_opnd),
    .i_div     (r_is_div),
    .o_acc     (w_step_acc),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_hi_write) r_hi <= i_wdata;
          if (i_lo_write) r_lo <= i_wdata;
          if (i_start) begin
            if (w_op_div && (i_b == '0)) begin
              r_done     <= 1'b1;
              r_div_zero <= 1'b1;
            end else begin
              r_state   <= S_CALC;
              r_count   <= '0;
              r_acc     <= {{WIDTH{1'b0}}, w_abs_a};
              r_opnd    <= w_abs_b;
              r_is_div  <= w_op_div;
              r_neg_res <= w_op_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
              r_neg_rem <= w_op_signed & i_a[WIDTH-1];
            end
          end
        end
        S_CALC: begin
          r_acc <= w_step_acc | {{(2*WIDTH-1){1'b0}}, w_qbit};
          if (r_count == CNT_W'(WIDTH - 1)) begin
            r_count <= '0;
            r_state <= S_FIX;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quot_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = r_done;
  assign o_div_zero = r_div_zero;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;
  assign o_state    = r_state;

endmodule
